// File: rtl/fetch_pkg.sv
// Shared Fetch-stage definitions: instruction address width and the
// redirect controller's state encoding.
package fetch_pkg;

    localparam int ADDR_WIDTH = 7;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } fetch_ctrl_state_t;

endpackage

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping.
module sat_counter
    import fetch_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_i,
    input  logic                 clear_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage sequencer: merges hazard stalls and branch mispredict redirects
// into Fetch's freeze/redirect/training inputs and generates flush pulses.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  RUN      | fetching normally
//  STALL    | a hazard held Fetch last cycle
//  REDIRECT | one-cycle redirect pulse to Fetch, pipeline flushed
//  FLUSH    | squashing younger instructions, FLUSH_CYCLES cycles
module fetch_redirect_ctrl #(
    parameter int ADDR_WIDTH   = fetch_pkg::ADDR_WIDTH,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Load_Use_Hazard,
    input  logic                  i_Mem_Busy,
    input  logic                  i_Branch_Resolved,
    input  logic                  i_Branch_Actual,
    input  logic                  i_Branch_Predicted,
    input  logic [ADDR_WIDTH-1:0] i_Branch_Pc,
    input  logic [ADDR_WIDTH-1:0] i_Branch_Target,
    output logic                  o_Freeze,
    output logic                  o_Branch_Taken,
    output logic [ADDR_WIDTH-1:0] o_Branch_Address,
    output logic                  o_Branch_Result,
    output logic                  o_Flush,
    output logic [1:0]            o_State,
    output logic [CNT_WIDTH-1:0]  o_Mispredict_Count
);
    import fetch_pkg::*;

    fetch_ctrl_state_t     state_q, state_d;
    logic [2:0]            flush_cnt_q, flush_cnt_d;
    logic                  taken_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  result_q;

    logic                  active;
    logic                  mispredict;
    logic                  stall_req;
    logic [ADDR_WIDTH-1:0] redirect_addr;

    // Resolutions seen while redirecting/flushing belong to squashed work.
    assign active        = (state_q == RUN) || (state_q == STALL);
    assign mispredict    = active & i_Branch_Resolved & (i_Branch_Actual ^ i_Branch_Predicted);
    assign stall_req     = i_Mem_Busy | i_Load_Use_Hazard;
    assign redirect_addr = i_Branch_Actual ? i_Branch_Target
                                           : i_Branch_Pc + ADDR_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN, STALL: begin
                if (mispredict) begin
                    state_d = REDIRECT;
                end else if (stall_req) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            REDIRECT: begin
                state_d     = FLUSH;
                flush_cnt_d = 3'(FLUSH_CYCLES - 1);
            end
            FLUSH: begin
                if (flush_cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            taken_q     <= 1'b0;
            addr_q      <= '0;
            result_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            taken_q     <= mispredict;
            if (mispredict) begin
                addr_q <= redirect_addr;
            end
            if (active && i_Branch_Resolved) begin
                result_q <= i_Branch_Actual;
            end
        end
    end

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_mispredict_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (mispredict),
        .clear_i (1'b0),
        .count_o (o_Mispredict_Count)
    );

    // Zero-latency freeze; never asserted while a redirect is being issued.
    assign o_Freeze         = stall_req & ~mispredict & active & ~reset;
    assign o_Branch_Taken   = taken_q;
    assign o_Branch_Address = addr_q;
    assign o_Branch_Result  = result_q;
    assign o_Flush          = (state_q == REDIRECT) || (state_q == FLUSH);
    assign o_State          = state_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed vector table, hand sequences for
// saturation and mid-redirect reset, then random traffic against a model.
module tb_fetch_redirect_ctrl;

    localparam int AW = 7;
    localparam int FC = 2;

    typedef struct {
        int rst, lu, mb, res, act, pred, pc, tgt;
        int frz, tkn, addr, bres, fl, st, cnt, cnts;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lu = 1'b0, mb = 1'b0, res = 1'b0, act = 1'b0, pred = 1'b0;
    logic [AW-1:0] pc = '0, tgt = '0;

    logic          frz, tkn, bres, fl;
    logic [AW-1:0] addr;
    logic [1:0]    st;
    logic [7:0]    cnt;
    logic          frz_s, tkn_s, bres_s, fl_s;
    logic [AW-1:0] addr_s;
    logic [1:0]    st_s;
    logic [1:0]    cnt_s;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_busy = 0;   // cycles of redirect+flush still to come (0 = normal fetch)
    int m_stall = 0, m_addr = 0, m_tkn = 0, m_res = 0, m_cnt = 0, m_cnts = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .i_Load_Use_Hazard(lu), .i_Mem_Busy(mb),
        .i_Branch_Resolved(res), .i_Branch_Actual(act), .i_Branch_Predicted(pred),
        .i_Branch_Pc(pc), .i_Branch_Target(tgt), .o_Freeze(frz), .o_Branch_Taken(tkn),
        .o_Branch_Address(addr), .o_Branch_Result(bres), .o_Flush(fl), .o_State(st),
        .o_Mispredict_Count(cnt));

    fetch_redirect_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(2)) dut_s (
        .clk(clk), .reset(reset), .i_Load_Use_Hazard(lu), .i_Mem_Busy(mb),
        .i_Branch_Resolved(res), .i_Branch_Actual(act), .i_Branch_Predicted(pred),
        .i_Branch_Pc(pc), .i_Branch_Target(tgt), .o_Freeze(frz_s), .o_Branch_Taken(tkn_s),
        .o_Branch_Address(addr_s), .o_Branch_Result(bres_s), .o_Flush(fl_s), .o_State(st_s),
        .o_Mispredict_Count(cnt_s));

    task automatic chk(input string nm, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, actual, expected, $time);
        end
    endtask

    function automatic int exp_state();
        if (m_busy == 0) return m_stall;
        if (m_busy == FC + 1) return 2;
        return 3;
    endfunction

    task automatic apply(input vec_t v, input bit use_tab);
        int active, misp, efrz;
        @(negedge clk);
        reset = (v.rst != 0);
        lu    = (v.lu != 0);
        mb    = (v.mb != 0);
        res   = (v.res != 0);
        act   = (v.act != 0);
        pred  = (v.pred != 0);
        pc    = AW'(v.pc);
        tgt   = AW'(v.tgt);
        #1;
        active = (m_busy == 0) ? 1 : 0;
        misp   = (active != 0 && v.res != 0 && v.act != v.pred) ? 1 : 0;
        efrz   = (active != 0 && (v.mb != 0 || v.lu != 0) && misp == 0 && v.rst == 0) ? 1 : 0;
        chk("freeze", int'(frz), efrz);
        chk("freeze_s", int'(frz_s), efrz);
        if (use_tab) chk("tab_freeze", int'(frz), v.frz);
        @(posedge clk);
        if (v.rst != 0) begin
            m_busy = 0; m_stall = 0; m_addr = 0; m_tkn = 0; m_res = 0; m_cnt = 0; m_cnts = 0;
        end else begin
            m_tkn = misp;
            if (misp != 0) begin
                m_addr  = (v.act != 0) ? v.tgt : (v.pc + 1) % (1 << AW);
                m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_cnts  = (m_cnts < 3) ? m_cnts + 1 : 3;
                m_busy  = FC + 1;
                m_stall = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                m_stall = 0;
            end else begin
                m_stall = (v.mb != 0 || v.lu != 0) ? 1 : 0;
            end
            if (active != 0 && v.res != 0) m_res = v.act;
        end
        #1;
        chk("state", int'(st), exp_state());
        chk("taken", int'(tkn), m_tkn);
        chk("addr", int'(addr), m_addr);
        chk("result", int'(bres), m_res);
        chk("flush", int'(fl), (m_busy > 0) ? 1 : 0);
        chk("count", int'(cnt), m_cnt);
        chk("state_s", int'(st_s), exp_state());
        chk("taken_s", int'(tkn_s), m_tkn);
        chk("addr_s", int'(addr_s), m_addr);
        chk("flush_s", int'(fl_s), (m_busy > 0) ? 1 : 0);
        chk("result_s", int'(bres_s), m_res);
        chk("count_s", int'(cnt_s), m_cnts);
        if (use_tab) begin
            chk("tab_taken", int'(tkn), v.tkn);
            chk("tab_addr", int'(addr), v.addr);
            chk("tab_result", int'(bres), v.bres);
            chk("tab_flush", int'(fl), v.fl);
            chk("tab_state", int'(st), v.st);
            chk("tab_count", int'(cnt), v.cnt);
            chk("tab_count_s", int'(cnt_s), v.cnts);
        end
    endtask

    vec_t vecs[24];
    vec_t idle, rst_v, misp_v, v;

    initial begin
        //            rst lu mb res act pred pc  tgt | frz tkn addr bres fl st cnt cnts
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0,   0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0,   0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0,   0, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 0, 0, 0,   0,   1, 0, 0,   0, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0,   0, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 1, 1, 0, 10,  20,  0, 1, 20,  1, 1, 2, 1, 1};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 20,  1, 1, 3, 1, 1};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 20,  1, 1, 3, 1, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 20,  1, 0, 0, 1, 1};
        vecs[9]  = '{0, 0, 0, 1, 0, 1, 127, 5,   0, 1, 0,   0, 1, 2, 2, 2};
        vecs[10] = '{0, 0, 1, 0, 0, 0, 0,   0,   0, 0, 0,   0, 1, 3, 2, 2};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0,   0, 1, 3, 2, 2};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0,   0, 0, 0, 2, 2};
        vecs[13] = '{0, 0, 1, 1, 1, 0, 3,   40,  0, 1, 40,  1, 1, 2, 3, 3};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 40,  1, 1, 3, 3, 3};
        vecs[15] = '{0, 0, 0, 1, 0, 1, 50,  9,   0, 0, 40,  1, 1, 3, 3, 3};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 40,  1, 0, 0, 3, 3};
        vecs[17] = '{0, 0, 0, 1, 0, 0, 60,  70,  0, 0, 40,  0, 0, 0, 3, 3};
        vecs[18] = '{0, 0, 0, 1, 1, 1, 61,  71,  0, 0, 40,  1, 0, 0, 3, 3};
        vecs[19] = '{0, 0, 1, 0, 0, 0, 0,   0,   1, 0, 40,  1, 0, 1, 3, 3};
        vecs[20] = '{0, 1, 1, 0, 0, 0, 0,   0,   1, 0, 40,  1, 0, 1, 3, 3};
        vecs[21] = '{0, 1, 0, 1, 1, 0, 7,   100, 0, 1, 100, 1, 1, 2, 4, 3};
        vecs[22] = '{0, 1, 0, 0, 0, 0, 0,   0,   0, 0, 100, 1, 1, 3, 4, 3};
        vecs[23] = '{1, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0,   0, 0, 0, 0, 0};

        idle   = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        rst_v  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        misp_v = '{0, 0, 0, 1, 1, 0, 33, 66, 0, 0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 24; i++) apply(vecs[i], 1'b1);

        // Five spaced mispredicts: narrow counter pins at 3, wide one keeps counting.
        for (int i = 0; i < 5; i++) begin
            apply(misp_v, 1'b0);
            for (int j = 0; j < FC + 1; j++) apply(idle, 1'b0);
        end
        chk("sat_count_s", int'(cnt_s), 3);
        chk("count_after_5", int'(cnt), 5);

        // Reset landing on the REDIRECT cycle aborts everything.
        apply(misp_v, 1'b0);
        chk("redirect_before_rst", int'(st), 2);
        apply(rst_v, 1'b0);
        chk("rst_mid_state", int'(st), 0);
        chk("rst_mid_flush", int'(fl), 0);
        chk("rst_mid_taken", int'(tkn), 0);
        chk("rst_mid_count", int'(cnt), 0);

        for (int i = 0; i < 3000; i++) begin
            v = idle;
            v.rst  = ($urandom_range(0, 79) == 0) ? 1 : 0;
            v.lu   = ($urandom_range(0, 4) == 0) ? 1 : 0;
            v.mb   = ($urandom_range(0, 4) == 0) ? 1 : 0;
            v.res  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            v.act  = int'($urandom_range(0, 1));
            v.pred = int'($urandom_range(0, 1));
            v.pc   = ($urandom_range(0, 7) == 0) ? 127 : int'($urandom_range(0, 127));
            v.tgt  = int'($urandom_range(0, 127));
            apply(v, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
